// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-lane writes and a registered read port.
// The read register returns to zero whenever no read is requested.
module dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      q
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem[idx];
        end else begin
            q <= '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with Req/Ready handshake and address checks.
// Define DMEM_BYTE_LANES_EN to honour BE; otherwise every store writes all lanes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WData,
    input  logic [3:0]        BE,
    output logic              Ready,
    output logic [31:0]       RData,
    output logic              AddrErr,
    output dmem_state_t       dbg_state
);

    // Handshake: Req (with WE/Addr/WData/BE) is sampled only in IDLE; the CPU holds
    // it until it sees the one-cycle Ready pulse, which carries RData and AddrErr.

    localparam int IDX_W = clog2(DEPTH_WORDS);
    localparam int OFF_W = clog2(WORD_BYTES);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t       state, next_state;
    logic [3:0]        cnt, cnt_next;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic              cur_err;
    logic              enter_resp;
    logic              ram_re;
    logic              ram_we;

    // With zero wait states RESP is entered on the accepting edge, so the
    // live request must feed the RAM index and error check while in IDLE.
    assign cur_addr = (state == IDLE) ? Addr : addr_q;
    assign cur_we   = (state == IDLE) ? WE : we_q;
    assign cur_err  = (cur_addr[OFF_W-1:0] != '0) || ((cur_addr >> (IDX_W + OFF_W)) != '0);

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (WAIT_STATES > 0) begin
                        next_state = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP);
    assign ram_re     = enter_resp && !cur_we && !cur_err;
    assign ram_we     = (state == RESP) && we_q && !cur_err;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            AddrErr <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            AddrErr <= enter_resp && cur_err;
            if (state == IDLE && Req) begin
                addr_q  <= Addr;
                we_q    <= WE;
                wdata_q <= WData;
`ifdef DMEM_BYTE_LANES_EN
                be_q    <= BE;
`else
                be_q    <= BE | 4'hF;
`endif
            end
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (CLK),
        .rst_n(Reset),
        .we   (ram_we),
        .be   (be_q),
        .re   (ram_re),
        .idx  (cur_addr[IDX_W+OFF_W-1:OFF_W]),
        .wdata(wdata_q),
        .q    (RData)
    );

    assign Ready     = (state == RESP);
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 64;
    localparam int WS_A  = 2;
    localparam int WS_B  = 0;

    logic        clk;
    logic        rst_n;
    logic        req_a, req_b, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ready_a, ready_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b;
    dmem_state_t dbg_a, dbg_b;

    logic        cur_sel;
    logic        s_ready, s_err;
    logic [31:0] s_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] err_q [$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A), .ADDR_W(32)) dut_a (
        .CLK(clk), .Reset(rst_n), .Req(req_a), .WE(we), .Addr(addr), .WData(wdata), .BE(be),
        .Ready(ready_a), .RData(rdata_a), .AddrErr(err_a), .dbg_state(dbg_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B), .ADDR_W(32)) dut_b (
        .CLK(clk), .Reset(rst_n), .Req(req_b), .WE(we), .Addr(addr), .WData(wdata), .BE(be),
        .Ready(ready_b), .RData(rdata_b), .AddrErr(err_b), .dbg_state(dbg_b)
    );

    assign s_ready = cur_sel ? ready_b : ready_a;
    assign s_rdata = cur_sel ? rdata_b : rdata_a;
    assign s_err   = cur_sel ? err_b : err_a;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // reference model
    function automatic bit addr_bad(input logic [31:0] a);
        return (a % WORD_BYTES != 0) || (a >= DEPTH * WORD_BYTES);
    endfunction

    function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic model_access(input bit sel, input bit w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] b,
                                output logic [31:0] rd, output logic [31:0] e);
        logic [3:0] eff;
        int idx;
`ifdef DMEM_BYTE_LANES_EN
        eff = b;
`else
        eff = 4'hF;
`endif
        e  = {31'd0, addr_bad(a)};
        rd = '0;
        if (e == 0) begin
            idx = int'(a / WORD_BYTES);
            if (w) begin
                if (sel) mem_b[idx] = apply_store(mem_b[idx], wd, eff);
                else     mem_a[idx] = apply_store(mem_a[idx], wd, eff);
            end else begin
                rd = sel ? mem_b[idx] : mem_a[idx];
            end
        end
    endtask

    // driver tasks
    task automatic do_access(input bit sel, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] rd, e;
        int lat;
        bit seen;
        model_access(sel, w, a, wd, b, rd, e);
        exp_q.push_back(rd);
        err_q.push_back(e);
        cur_sel = sel;
        @(negedge clk);
        we = w; addr = a; wdata = wd; be = b;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (s_ready) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check_eq("ready_seen", {31'd0, seen}, 32'd1);
        if (!seen) begin
            exp_q.delete();
            err_q.delete();
            return;
        end
        check_eq("latency", lat, sel ? WS_B : WS_A);
        check_eq("rdata", s_rdata, exp_q.pop_front());
        check_eq("addr_err", {31'd0, s_err}, err_q.pop_front());
        @(posedge clk); #1;
        check_eq("after_resp", {s_ready, s_err, s_rdata[29:0]}, 32'd0);
    endtask

    task automatic hold_loads(input bit sel, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2);
        logic [31:0] al [3];
        logic [31:0] rd, e;
        int ws, edges, last, k, extra;
        al[0] = a0; al[1] = a1; al[2] = a2;
        ws = sel ? WS_B : WS_A;
        for (int j = 0; j < 3; j++) begin
            model_access(sel, 1'b0, al[j], 32'd0, 4'h0, rd, e);
            exp_q.push_back(rd);
            err_q.push_back(e);
        end
        cur_sel = sel;
        @(negedge clk);
        we = 1'b0; addr = al[0]; be = 4'h0;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        edges = 0; last = 0; k = 0;
        for (int i = 0; i < 80 && k < 3; i++) begin
            @(posedge clk); #1;
            edges++;
            if (s_ready) begin
                if (k == 0) check_eq("hold_first_lat", edges, ws + 1);
                else        check_eq("hold_spacing", edges - last, ws + 2);
                last = edges;
                check_eq("hold_rdata", s_rdata, exp_q.pop_front());
                check_eq("hold_err", {31'd0, s_err}, err_q.pop_front());
                k++;
                if (k < 3) addr = al[k];
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check_eq("hold_count", k, 3);
        exp_q.delete();
        err_q.delete();
        extra = 0;
        repeat (ws + 4) begin
            @(posedge clk); #1;
            if (s_ready) extra++;
        end
        check_eq("hold_no_dup", extra, 0);
    endtask

    task automatic random_access(input bit sel);
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
        else if (r == 7) a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        else if (r == 8) a = 32'(DEPTH * WORD_BYTES) + $urandom_range(0, 1 << 20);
        else             a = $urandom;
        do_access(sel, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        int rdy_cnt;
        cur_sel = 1'b0;
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready_a", {31'd0, ready_a}, 32'd0);
        check_eq("rst_rdata_a", rdata_a, 32'd0);
        check_eq("rst_err_a", {31'd0, err_a}, 32'd0);
        check_eq("rst_state_a", dbg_a, IDLE);
        check_eq("rst_state_b", dbg_b, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // fill both memories so the model knows every word
        for (int i = 0; i < DEPTH; i++) do_access(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < DEPTH; i++) do_access(1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF);

        // directed cases
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        do_access(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'h1);
        do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        do_access(1'b0, 1'b1, 32'h10, 32'h11111111, 4'h0);
        do_access(1'b0, 1'b0, 32'h12, 32'h0, 4'h0);
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        do_access(1'b0, 1'b1, 32'h12, 32'h55555555, 4'hF);
        do_access(1'b0, 1'b1, 32'h110, 32'h66666666, 4'hF);
        do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        do_access(1'b1, 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF);
        do_access(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0);
        do_access(1'b1, 1'b0, 32'hFF, 32'h0, 4'h0);
        do_access(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0);

        hold_loads(1'b0, 32'h10, 32'h24, 32'h3FC);
        hold_loads(1'b1, 32'h3C, 32'h00, 32'h102);

        // reset in the middle of a store's wait period
        cur_sel = 1'b0;
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF; req_a = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_wait", dbg_a, WAIT);
        #1;
        rst_n = 1'b0;
        req_a = 1'b0;
        #1;
        check_eq("midrst_idle", dbg_a, IDLE);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready_a) rdy_cnt++;
        end
        check_eq("midrst_no_ready", rdy_cnt, 0);
        do_access(1'b0, 1'b0, 32'h20, 32'h0, 4'h0);

        // randomized traffic on both latency configurations
        for (int i = 0; i < 40; i++) random_access(1'b0);
        for (int i = 0; i < 30; i++) random_access(1'b1);
        for (int i = 0; i < DEPTH; i += 7) do_access(1'b0, 1'b0, 32'(i * 4), 32'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data port. The CPU presents the address (ALU result), the write data and the write enable. This block answers with read data after a programmable number of wait states.
- It replaces the zero-latency data memory, so the pipeline can be exercised against a slow memory using a Req/Ready handshake.
- Holds a word-addressed RAM with byte-lane writes. Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words stored. Must be a power of two, at least 4.
- WAIT_STATES, 2: cycles between request acceptance and the Ready cycle, minus 1. Range 0..15.
- ADDR_W, 32: width of the CPU byte address.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  CPU access request; sampled only in IDLE.
- WE  in  1  1 = store, 0 = load; qualified by Req.
- Addr  in  ADDR_W  byte address.
- WData  in  32  store data.
- BE  in  4  byte enables; BE[i] selects WData[8i+7:8i].
- Ready  out  1  one-cycle pulse marking completion.
- RData  out  32  load data; valid only while Ready=1.
- AddrErr  out  1  error flag; valid only while Ready=1.

Behaviour:
- Reset (Reset=0, at any time, including mid-access):
  - FSM goes to IDLE, wait counter to 0.
  - Ready=0, RData=0, AddrErr=0.
  - Any pending store is abandoned. RAM contents are not cleared.
- States:
  - IDLE: if Req=1 at the edge, latch Addr/WE/WData/BE. Go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: counter loaded with WAIT_STATES-1 on entry and decremented each cycle. At 0, go to RESP.
  - RESP: Ready=1 for exactly this cycle, then IDLE unconditionally.
- Latency: request accepted at edge t gives Ready=1 during cycle t+1+WAIT_STATES. Minimum request-to-request spacing is WAIT_STATES+2 cycles.
- Req while in WAIT or RESP is ignored (not queued). The CPU must hold Req until it observes Ready.
- Word index is Addr[log2(DEPTH_WORDS)+1:2].
- Error conditions:
  - Misaligned: Addr[1:0]!=0.
  - Out of range: any Addr bit at or above log2(DEPTH_WORDS)+2 is set.
  - On error: AddrErr=1 in RESP, RData=0, no RAM write.
- Store:
  - Enabled lanes are written at the edge leaving RESP.
  - RData=0 during a store's Ready cycle.
  - BE=0000 completes normally with no change.
- Load: RData is the word as of the edge entering RESP. A load immediately after a store to the same word returns the new data.
- Address wrap-around is not performed; out-of-range addresses always error.
- RData and AddrErr are registered outputs and return to 0 outside RESP.

Optional Feature:
- Macro: DMEM_BYTE_LANES_EN.
- Defined: BE honoured per lane as above.
- Undefined: BE ignored; every store writes all 32 bits (equivalent to BE=1111). The port still exists and is left unconnected internally.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t
  - WORD_BYTES=4
  - constant function clog2 for the index width
- Sub-module dmem_ram: synchronous single-port RAM (DEPTH_WORDS x 32) with 4-bit byte write enable and registered read. The FSM, counter and error checks stay in dmem_responder.

Test Plan:
- Reset, then store 0xDEADBEEF to Addr 0x10 with BE=1111 and WAIT_STATES=2 -> Ready pulses exactly 3 cycles after acceptance, AddrErr=0. A later load from 0x10 returns RData=0xDEADBEEF.
- Store 0x000000AA to 0x10 with BE=0001 -> load from 0x10 returns 0xDEADBEAA (with DMEM_BYTE_LANES_EN), or 0x000000AA (without).
- Load from 0x12 (misaligned) and from 0x100 with DEPTH_WORDS=64 (out of range) -> Ready=1, AddrErr=1, RData=0. Memory is unchanged (0x10 still reads the prior value).
- Hold Req=1 continuously through three loads -> exactly one Ready per WAIT_STATES+2 cycles, no duplicate or dropped accesses. With WAIT_STATES=0, Ready arrives the cycle after acceptance.
- Assert Reset=0 for 1 cycle during WAIT of a store of 0x12345678 to 0x20 -> Ready never pulses, FSM returns to IDLE, and a load from 0x20 returns its pre-store value.
